// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter onto a single memory port whose read data
// returns exactly one cycle after the read strobe.
module dm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic [15:0]     conflict_cnt
);

    localparam int BW = DW / 8;

    logic        last_q, last_d;        // 1'b1: m1 won the most recent grant
    logic [1:0]  rd_pend_q, rd_pend_d;  // one-hot owner of the read in flight
    logic [15:0] cnt_q, cnt_d;
    logic        g0_s, g1_s;

    // Round-robin grant; both grants forced low while reset is asserted
    always_comb begin
        g0_s = 1'b0;
        g1_s = 1'b0;
        if (!rstn) begin
            g0_s = 1'b0;
            g1_s = 1'b0;
        end else if (m0_req && m1_req) begin
            g0_s = last_q;
            g1_s = ~last_q;
        end else begin
            g0_s = m0_req;
            g1_s = m1_req;
        end
    end

    // Memory port mux from the winning requester
    always_comb begin
        mem_en    = g0_s | g1_s;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_be    = {BW{1'b0}};
        case ({g1_s, g0_s})
            2'b01: begin
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_be    = m0_be;
            end
            2'b10: begin
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_be    = m1_be;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
                mem_be    = {BW{1'b0}};
            end
        endcase
    end

    // Next-state for last winner, read-response owner and saturating conflict count
    always_comb begin
        last_d    = last_q;
        rd_pend_d = {g1_s & ~m1_we, g0_s & ~m0_we};
        cnt_d     = cnt_q;
        if (g0_s || g1_s) begin
            last_d = g1_s;
        end else begin
            last_d = last_q;
        end
        if (m0_req && m1_req && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops any read response still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q    <= 1'b1;
            rd_pend_q <= 2'b00;
            cnt_q     <= 16'd0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    // Read response steering; data is zero whenever its valid is low
    always_comb begin
        m0_rvalid = rd_pend_q[0];
        m1_rvalid = rd_pend_q[1];
        if (rd_pend_q[0]) begin
            m0_rdata = mem_rdata;
        end else begin
            m0_rdata = {DW{1'b0}};
        end
        if (rd_pend_q[1]) begin
            m1_rdata = mem_rdata;
        end else begin
            m1_rdata = {DW{1'b0}};
        end
    end

    assign m0_gnt       = g0_s;
    assign m1_gnt       = g1_s;
    assign conflict_cnt = cnt_q;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, 32, data width; byte-enable width is DW/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 m0_req  input  1  CPU load/store request.
REQ-006 m0_we  input  1  CPU write when 1, read when 0.
REQ-007 m0_addr  input  AW  CPU byte address.
REQ-008 m0_wdata  input  DW  CPU write data.
REQ-009 m0_be  input  DW/8  CPU byte enables.
REQ-010 m0_gnt  output  1  CPU request accepted this cycle.
REQ-011 m0_rvalid  output  1  CPU read data valid.
REQ-012 m0_rdata  output  DW  CPU read data.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata  same directions and widths as m0_*, for the debug/loader requester.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_we  output  1  memory write strobe.
REQ-016 mem_addr  output  AW  memory address.
REQ-017 mem_wdata  output  DW  memory write data.
REQ-018 mem_be  output  DW/8  memory byte enables.
REQ-019 mem_rdata  input  DW  memory read data, valid exactly one cycle after a read strobe.
REQ-020 conflict_cnt  output  16  count of cycles in which both requesters asserted req.

Function
REQ-021 The block SHALL accept at most one request per cycle and SHALL accept one every cycle while any req is high (no bubbles).
REQ-022 Grant SHALL be combinational: mxgnt=1 in the same cycle as the winning mxreq, and at most one gnt SHALL be high.
REQ-023 With a single requester active, that requester SHALL win.
REQ-024 With both active, the requester not recorded in last_grant SHALL win (round-robin).
REQ-025 last_grant SHALL update to the winner on every cycle with a grant and SHALL hold otherwise.
REQ-026 mem_en SHALL equal (m0_gnt|m1_gnt); mem_we, mem_addr, mem_wdata, mem_be SHALL be muxed from the winner; with no grant, mem_we=0 and mem_be=0.
REQ-027 An accepted read SHALL produce mxrvalid=1 for exactly one cycle, one cycle after the grant, to the granted requester only, with mxrdata=mem_rdata in that cycle.
REQ-028 Writes SHALL produce no rvalid.
REQ-029 Back-to-back reads from alternating requesters SHALL return responses in grant order, each to its own requester.
REQ-030 mxrdata SHALL be 0 when mxrvalid=0.
REQ-031 conflict_cnt SHALL increment by 1 on each cycle with m0_req&m1_req and SHALL saturate at 16'hFFFF.
REQ-032 A request not granted SHALL remain pending under requester control; the arbiter SHALL hold no request state.

Reset
REQ-033 While rstn=0: gnt and rvalid outputs 0, mem_en=0, mem_we=0, mem_be=0, conflict_cnt=0, last_grant=m1, so the first conflict after reset goes to m0.
REQ-034 Reset asserted with a read response pending SHALL drop the response; no rvalid SHALL appear after release.
REQ-035 The first edge after rstn rises SHALL accept requests normally.

Verification
REQ-036 Reset, then m0 read at addr 0x10 alone, mem_rdata=0xDEADBEEF next cycle -> m0_gnt same cycle, m0_rvalid=1 with 0xDEADBEEF one cycle later, m1_rvalid=0.
REQ-037 Both requesters read continuously for 4 cycles after reset -> grants m0,m1,m0,m1; rvalids follow one cycle later in the same order; conflict_cnt=4.
REQ-038 m1 write addr 0x4, wdata 0x12345678, be 4'b1111 -> mem_en=1, mem_we=1, mem_addr=0x4, mem_wdata=0x12345678; no rvalid on either port.
REQ-039 m0 read granted, rstn pulled low before the next edge -> no m0_rvalid after release; conflict_cnt=0.
REQ-040 Hold both req high for 65540 cycles -> conflict_cnt stops at 16'hFFFF; grants keep alternating.
REQ-041 Idle cycle with no req -> mem_en=0, mem_we=0, mem_be=0; last_grant unchanged, checked by the next conflict going to the requester not granted before the idle cycle.
